rssi_accum: RTL and testbench
=============================

Name: rssi_accum

Overview:
- Downstream consumer of the RSSI window-tick generator in the clk_15p36 domain.
- Computes instantaneous power I²+Q² on each valid baseband sample.
- Accumulates power and tracks the peak over each measurement window.
- On every rssi_load pulse, snapshots sum, peak and sample count into a result register. The result is held with a valid/ack handshake for the register interface.

Parameters:
- IQ_W, 16, signed I/Q sample width.
- ACC_W, 48, power accumulator width; must be at least 2*IQ_W.
- CNT_W, 21, sample-counter width; matches the window tick counter width.

Ports:
- clk_15p36  input  1  block clock.
- reset_15p36  input  1  asynchronous, active-high reset.
- sample_valid  input  1  sample_i and sample_q are valid this cycle.
- sample_i  input  IQ_W  signed in-phase sample.
- sample_q  input  IQ_W  signed quadrature sample.
- rssi_load  input  1  single-cycle window-end pulse from the window generator.
- rssi_ack  input  1  register interface has consumed the result; clears rssi_valid.
- rssi_valid  output  1  result fields hold an unconsumed result.
- rssi_pwr_sum  output  ACC_W  sum of I²+Q² over the closed window.
- rssi_pwr_peak  output  2*IQ_W  maximum I²+Q² in the closed window.
- rssi_smp_cnt  output  CNT_W  number of valid samples in the closed window.
- rssi_sat  output  1  accumulator or counter saturated during the closed window.
- rssi_overrun  output  1  sticky: a new result arrived while rssi_valid was still high.

Behaviour:
- Reset: asynchronous, active-high, on reset_15p36. All outputs, pipeline registers, accumulator, peak, counter and state go to 0. The block resumes in state IDLE on the first clock after deassertion.
- Power pipeline (2 stages):
  - Stage 1 registers I² and Q², each unsigned 2*IQ_W-1 bits.
  - Stage 2 registers pwr = I²+Q², unsigned 2*IQ_W bits; maximum value 2^31 at the -32768 corners.
  - The sample_valid qualifier travels with the data.
  - rssi_load is delayed by 2 cycles (load_d2) to stay aligned with the pipeline.
- Window membership: a sample with sample_valid high on the same cycle as rssi_load belongs to the window that rssi_load closes.
- State machine, two states:
  - IDLE: no window closed yet. Accumulation runs, but the first load_d2 only discards the partial window (clears acc, peak, cnt) and moves to RUN. No result is produced; this avoids reporting a partial first window.
  - RUN: every load_d2 commits a result.
  - Only reset returns the block to IDLE.
- Accumulate (cycle with valid pwr and no load_d2):
  - acc += pwr, saturating at all-ones; saturation sets sat_int.
  - cnt += 1, saturating at all-ones; saturation also sets sat_int.
  - peak = max(peak, pwr).
- Commit (load_d2 in RUN):
  - The final in-flight pwr from that same cycle is included in the sum, count and peak.
  - Output registers load in the same cycle, so results appear 3 cycles after rssi_load.
  - acc, cnt, peak and sat_int clear to 0 the same cycle.
  - The next window starts empty; there is no double-count and no lost sample.
- Handshake:
  - rssi_valid goes high on commit and stays high until a cycle with rssi_ack high.
  - If commit and ack occur in the same cycle, commit wins: rssi_valid stays 1 with the new data.
  - Commit while rssi_valid is 1 and no ack that cycle overwrites the data and sets rssi_overrun.
  - rssi_overrun clears only on an rssi_ack cycle with no coincident overrun.
- Back-to-back loads 1 cycle apart are legal. Each produces an independent result; an empty window gives sum 0, cnt 0, peak 0.
- rssi_ack with rssi_valid low has no effect.
- Output fields stay stable while rssi_valid is high, except when overwritten by a commit.

Decomposition:
- Package rssi_pkg:
  - IQ_W, ACC_W and CNT_W defaults.
  - typedef rssi_result_t packed struct {pwr_sum, pwr_peak, smp_cnt, sat}.
  - enum rssi_state_e {IDLE, RUN}.
- Sub-module rssi_pwr_calc: the 2-stage I²+Q² pipeline with valid and load delay. Reusable by other power meters.

Test Plan:
- Reset mid-window: assert reset_15p36 after 5 samples, then apply 10 samples of I=100, Q=0 and 2 loads. The first load produces no result. The second gives sum 10*10000=100000 (if all 10 samples fall in window 2), cnt 10.
- Steady state: constant I=3, Q=4 every cycle, loads every 100 cycles. Each result: sum 2500, peak 25, cnt 100, rssi_valid rises exactly 3 cycles after rssi_load.
- Boundary sample: a single I=1000, Q=0 sample on the rssi_load cycle counts in the closing window (peak 1000000). The following window's cnt excludes it.
- Corner and saturation: I=Q=-32768 gives peak 2^31. With ACC_W=33, a long run saturates at 2^33-1 and sets rssi_sat; the next window's sat is 0.
- Handshake: no ack across two commits sets rssi_overrun with the second window's data. Ack coincident with a commit leaves rssi_valid high. A later ack alone clears both rssi_valid and rssi_overrun.
- Loads on consecutive cycles with sample_valid low: two results, each with sum 0, cnt 0, peak 0.

Source files
------------

// File: rtl/rssi_pkg.sv
// rssi_pkg: shared types and default widths for the RSSI power accumulator.
//   IQ_W_DEF  - default signed I/Q sample width
//   ACC_W_DEF - default power accumulator width (at least 2*IQ_W)
//   CNT_W_DEF - default sample-counter width (matches the window tick counter)
//   rssi_result_t - one committed window result
//   rssi_state_e  - accumulator control state
package rssi_pkg;

    localparam int IQ_W_DEF  = 16;
    localparam int ACC_W_DEF = 48;
    localparam int CNT_W_DEF = 21;

    typedef struct packed {
        logic [ACC_W_DEF-1:0]    pwr_sum;
        logic [2*IQ_W_DEF-1:0]   pwr_peak;
        logic [CNT_W_DEF-1:0]    smp_cnt;
        logic                    sat;
    } rssi_result_t;

    // IDLE: no window closed since reset; RUN: every window end commits.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rssi_state_e;

endpackage

// File: rtl/rssi_pwr_calc.sv
// rssi_pwr_calc: two-stage instantaneous power pipeline, pwr = I^2 + Q^2.
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid          - in_i / in_q valid this cycle
//   in_i, in_q        - signed samples
//   in_load           - side-band strobe delayed alongside the data
//   out_valid/out_pwr - qualified power, 2 cycles after the input
//   out_load          - in_load delayed by 2 cycles
module rssi_pwr_calc
    import rssi_pkg::*;
#(
    parameter int IQ_W = IQ_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IQ_W-1:0]   in_i,
    input  logic [IQ_W-1:0]   in_q,
    input  logic              in_load,
    output logic              out_valid,
    output logic [2*IQ_W-1:0] out_pwr,
    output logic              out_load
);

    localparam int PWR_W = 2 * IQ_W;
    // A square of a signed IQ_W value never exceeds 2^(2*IQ_W-2), so one bit less than PWR_W suffices.
    localparam int SQ_W  = 2 * IQ_W - 1;

    logic signed [PWR_W-1:0] i_ext_s, q_ext_s;
    logic signed [PWR_W-1:0] i_prod_s, q_prod_s;

    logic             v1_d, v1_q;
    logic             ld1_d, ld1_q;
    logic [SQ_W-1:0]  i_sq_d, i_sq_q;
    logic [SQ_W-1:0]  q_sq_d, q_sq_q;
    logic             v2_d, v2_q;
    logic             ld2_d, ld2_q;
    logic [PWR_W-1:0] pwr_d, pwr_q;

    // Stage 1 and stage 2 next-state: squares, then their sum; data zeroed when not valid.
    always_comb begin
        i_ext_s  = {{IQ_W{in_i[IQ_W-1]}}, in_i};
        q_ext_s  = {{IQ_W{in_q[IQ_W-1]}}, in_q};
        i_prod_s = i_ext_s * i_ext_s;
        q_prod_s = q_ext_s * q_ext_s;
        v1_d     = in_valid;
        ld1_d    = in_load;
        if (in_valid) begin
            i_sq_d = i_prod_s[SQ_W-1:0];
            q_sq_d = q_prod_s[SQ_W-1:0];
        end else begin
            i_sq_d = '0;
            q_sq_d = '0;
        end
        v2_d  = v1_q;
        ld2_d = ld1_q;
        pwr_d = {1'b0, i_sq_q} + {1'b0, q_sq_q};
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            ld1_q  <= 1'b0;
            i_sq_q <= '0;
            q_sq_q <= '0;
            v2_q   <= 1'b0;
            ld2_q  <= 1'b0;
            pwr_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            ld1_q  <= ld1_d;
            i_sq_q <= i_sq_d;
            q_sq_q <= q_sq_d;
            v2_q   <= v2_d;
            ld2_q  <= ld2_d;
            pwr_q  <= pwr_d;
        end
    end

    assign out_valid = v2_q;
    assign out_pwr   = pwr_q;
    assign out_load  = ld2_q;

endmodule

// File: rtl/rssi_accum.sv
// rssi_accum: per-window RSSI power sum / peak / sample count with a
// valid/ack result register.
//   clk_15p36, reset_15p36    - clock, asynchronous active-high reset
//   sample_valid, sample_i/q  - baseband samples
//   rssi_load                 - window-end pulse (closes the window incl. this cycle's sample)
//   rssi_ack                  - result consumed
//   rssi_valid                - result held and not yet consumed
//   rssi_pwr_sum/peak/smp_cnt - closed window sum, maximum, sample count
//   rssi_sat                  - accumulator or counter saturated in that window
//   rssi_overrun              - sticky: result overwritten before it was acked
module rssi_accum
    import rssi_pkg::*;
#(
    parameter int IQ_W  = IQ_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk_15p36,
    input  logic              reset_15p36,
    input  logic              sample_valid,
    input  logic [IQ_W-1:0]   sample_i,
    input  logic [IQ_W-1:0]   sample_q,
    input  logic              rssi_load,
    input  logic              rssi_ack,
    output logic              rssi_valid,
    output logic [ACC_W-1:0]  rssi_pwr_sum,
    output logic [2*IQ_W-1:0] rssi_pwr_peak,
    output logic [CNT_W-1:0]  rssi_smp_cnt,
    output logic              rssi_sat,
    output logic              rssi_overrun
);

    localparam int PWR_W = 2 * IQ_W;

    logic             pwr_valid_s;
    logic [PWR_W-1:0] pwr_s;
    logic             load_d2_s;

    rssi_pwr_calc #(
        .IQ_W (IQ_W)
    ) u_pwr_calc (
        .clk       (clk_15p36),
        .rst       (reset_15p36),
        .in_valid  (sample_valid),
        .in_i      (sample_i),
        .in_q      (sample_q),
        .in_load   (rssi_load),
        .out_valid (pwr_valid_s),
        .out_pwr   (pwr_s),
        .out_load  (load_d2_s)
    );

    rssi_state_e      state_d, state_q;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic [PWR_W-1:0] peak_d, peak_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sat_d, sat_q;

    logic             valid_d, valid_q;
    logic [ACC_W-1:0] o_sum_d, o_sum_q;
    logic [PWR_W-1:0] o_peak_d, o_peak_q;
    logic [CNT_W-1:0] o_cnt_d, o_cnt_q;
    logic             o_sat_d, o_sat_q;
    logic             overrun_d, overrun_q;

    // Window totals including this cycle's in-flight sample; used both to
    // accumulate and to commit, so the closing sample is never lost.
    logic [ACC_W:0]   acc_sum_s;
    logic [ACC_W-1:0] acc_upd_s;
    logic [CNT_W-1:0] cnt_upd_s;
    logic [PWR_W-1:0] peak_upd_s;
    logic             sat_upd_s;
    logic             commit_s;

    // Saturating accumulate of the current sample into the window totals.
    always_comb begin
        acc_sum_s  = {1'b0, acc_q} + {{(ACC_W + 1 - PWR_W){1'b0}}, pwr_s};
        acc_upd_s  = acc_q;
        cnt_upd_s  = cnt_q;
        peak_upd_s = peak_q;
        sat_upd_s  = sat_q;
        if (pwr_valid_s) begin
            if (acc_sum_s[ACC_W]) begin
                acc_upd_s = '1;
                sat_upd_s = 1'b1;
            end else begin
                acc_upd_s = acc_sum_s[ACC_W-1:0];
            end
            if (&cnt_q) begin
                cnt_upd_s = cnt_q;
                sat_upd_s = 1'b1;
            end else begin
                cnt_upd_s = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
            if (pwr_s > peak_q) begin
                peak_upd_s = pwr_s;
            end else begin
                peak_upd_s = peak_q;
            end
        end else begin
            acc_upd_s  = acc_q;
            cnt_upd_s  = cnt_q;
            peak_upd_s = peak_q;
            sat_upd_s  = sat_q;
        end
    end

    // Control: window close/discard, result commit and valid/ack/overrun handshake.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_upd_s;
        cnt_d     = cnt_upd_s;
        peak_d    = peak_upd_s;
        sat_d     = sat_upd_s;
        valid_d   = valid_q;
        o_sum_d   = o_sum_q;
        o_peak_d  = o_peak_q;
        o_cnt_d   = o_cnt_q;
        o_sat_d   = o_sat_q;
        overrun_d = overrun_q;
        commit_s  = 1'b0;

        case (state_q)
            IDLE: begin
                // First window after reset is partial: drop it without a result.
                if (load_d2_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                state_d  = RUN;
                commit_s = load_d2_s;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_d2_s) begin
            acc_d  = '0;
            cnt_d  = '0;
            peak_d = '0;
            sat_d  = 1'b0;
        end else begin
            acc_d  = acc_upd_s;
            cnt_d  = cnt_upd_s;
            peak_d = peak_upd_s;
            sat_d  = sat_upd_s;
        end

        // A commit beats a coincident ack; it only counts as an overrun
        // when the previous result is still unconsumed and not acked now.
        if (commit_s) begin
            valid_d   = 1'b1;
            o_sum_d   = acc_upd_s;
            o_peak_d  = peak_upd_s;
            o_cnt_d   = cnt_upd_s;
            o_sat_d   = sat_upd_s;
            overrun_d = ~rssi_ack & (valid_q | overrun_q);
        end else if (rssi_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d   = valid_q;
            overrun_d = overrun_q;
        end
    end

    // Window state and result registers.
    always_ff @(posedge clk_15p36 or posedge reset_15p36) begin
        if (reset_15p36) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            peak_q    <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            o_sum_q   <= '0;
            o_peak_q  <= '0;
            o_cnt_q   <= '0;
            o_sat_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            peak_q    <= peak_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            o_sum_q   <= o_sum_d;
            o_peak_q  <= o_peak_d;
            o_cnt_q   <= o_cnt_d;
            o_sat_q   <= o_sat_d;
            overrun_q <= overrun_d;
        end
    end

    assign rssi_valid    = valid_q;
    assign rssi_pwr_sum  = o_sum_q;
    assign rssi_pwr_peak = o_peak_q;
    assign rssi_smp_cnt  = o_cnt_q;
    assign rssi_sat      = o_sat_q;
    assign rssi_overrun  = overrun_q;

endmodule

// File: tb/tb_rssi_accum.sv
// tb_rssi_accum: directed, table-driven bench for rssi_accum. A second
// instance with a 33-bit accumulator shares the stimulus for saturation.
module tb_rssi_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        sv, ld, ack;
    logic [15:0] si, sq;

    logic        a_valid, a_sat, a_ovr;
    logic [47:0] a_sum;
    logic [31:0] a_peak;
    logic [20:0] a_cnt;

    logic        b_valid, b_sat, b_ovr;
    logic [32:0] b_sum;
    logic [31:0] b_peak;
    logic [20:0] b_cnt;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        int          n;
        bit          on_load;
        logic [63:0] e_sum;
        logic [63:0] e_peak;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    rssi_accum dut (
        .clk_15p36     (clk),
        .reset_15p36   (reset),
        .sample_valid  (sv),
        .sample_i      (si),
        .sample_q      (sq),
        .rssi_load     (ld),
        .rssi_ack      (ack),
        .rssi_valid    (a_valid),
        .rssi_pwr_sum  (a_sum),
        .rssi_pwr_peak (a_peak),
        .rssi_smp_cnt  (a_cnt),
        .rssi_sat      (a_sat),
        .rssi_overrun  (a_ovr)
    );

    rssi_accum #(.IQ_W(16), .ACC_W(33), .CNT_W(21)) dut_sat (
        .clk_15p36     (clk),
        .reset_15p36   (reset),
        .sample_valid  (sv),
        .sample_i      (si),
        .sample_q      (sq),
        .rssi_load     (ld),
        .rssi_ack      (ack),
        .rssi_valid    (b_valid),
        .rssi_pwr_sum  (b_sum),
        .rssi_pwr_peak (b_peak),
        .rssi_smp_cnt  (b_cnt),
        .rssi_sat      (b_sat),
        .rssi_overrun  (b_ovr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic ev, input logic [63:0] es,
                           input logic [63:0] ep, input logic [63:0] ec,
                           input logic esat, input logic eovr);
        chk({tag, ".valid"},   {63'd0, a_valid}, {63'd0, ev});
        chk({tag, ".sum"},     {16'd0, a_sum},   es);
        chk({tag, ".peak"},    {32'd0, a_peak},  ep);
        chk({tag, ".cnt"},     {43'd0, a_cnt},   ec);
        chk({tag, ".sat"},     {63'd0, a_sat},   {63'd0, esat});
        chk({tag, ".overrun"}, {63'd0, a_ovr},   {63'd0, eovr});
    endtask

    // One clock: apply inputs, pass the rising edge, settle 1 time unit.
    task automatic cyc(input logic v, input logic [15:0] i, input logic [15:0] q,
                       input logic l, input logic a);
        sv = v; si = i; sq = q; ld = l; ack = a;
        @(posedge clk);
        #1;
        sv = 1'b0; si = 16'd0; sq = 16'd0; ld = 1'b0; ack = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{16'd3,    16'd4,    100, 1'b0, 64'd2500,       64'd25,         64'd100};
        tbl[1] = '{16'd3,    16'd4,    100, 1'b0, 64'd2500,       64'd25,         64'd100};
        tbl[2] = '{16'd1000, 16'd0,    1,   1'b1, 64'd1000000,    64'd1000000,    64'd1};
        tbl[3] = '{16'd0,    16'd0,    0,   1'b0, 64'd0,          64'd0,          64'd0};
        tbl[4] = '{16'h8000, 16'h8000, 1,   1'b0, 64'd2147483648, 64'd2147483648, 64'd1};
        tbl[5] = '{16'hFFFB, 16'd7,    3,   1'b1, 64'd222,        64'd74,         64'd3};
        tbl[6] = '{16'd100,  16'hFF9C, 2,   1'b0, 64'd40000,      64'd20000,      64'd2};

        reset = 1'b1;
        sv = 1'b0; si = 16'd0; sq = 16'd0; ld = 1'b0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_res("reset", 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Reset mid-window, then a partial window that must be discarded.
        for (int k = 0; k < 5; k++) cyc(1'b1, 16'd100, 16'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_res("mid_reset", 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'b1, 16'd100, 16'd0, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        repeat (4) idle();
        chk("first_load_no_result", {63'd0, a_valid}, 64'd0);
        for (int k = 0; k < 10; k++) cyc(1'b1, 16'd100, 16'd0, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        idle();
        chk("win2_latency", {63'd0, a_valid}, 64'd0);
        idle();
        chk_res("win2", 1'b1, 64'd100000, 64'd10000, 64'd10, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        chk("win2_ack", {63'd0, a_valid}, 64'd0);

        // Table-driven windows; result must appear exactly 3 cycles after the load.
        for (int t = 0; t < 7; t++) begin
            for (int j = 0; j < tbl[t].n; j++)
                cyc(1'b1, tbl[t].i, tbl[t].q, (tbl[t].on_load && j == tbl[t].n - 1), 1'b0);
            if (!tbl[t].on_load || tbl[t].n == 0)
                cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_lat0", t), {63'd0, a_valid}, 64'd0);
            idle();
            chk($sformatf("tbl%0d_lat1", t), {63'd0, a_valid}, 64'd0);
            idle();
            chk_res($sformatf("tbl%0d", t), 1'b1, tbl[t].e_sum, tbl[t].e_peak, tbl[t].e_cnt, 1'b0, 1'b0);
            cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_ack", t), {63'd0, a_valid}, 64'd0);
        end

        // Peak tracking with varying power: 1, 200, 8.
        cyc(1'b1, 16'd1,  16'd0,  1'b0, 1'b0);
        cyc(1'b1, 16'd10, 16'd10, 1'b0, 1'b0);
        cyc(1'b1, 16'd2,  16'd2,  1'b0, 1'b0);
        cyc(1'b0, 16'd0,  16'd0,  1'b1, 1'b0);
        idle();
        idle();
        chk_res("peak_var", 1'b1, 64'd209, 64'd200, 64'd3, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

        // Handshake: commit, commit with coincident ack, commit without ack, lone ack.
        cyc(1'b1, 16'd3, 16'd4, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        idle();
        idle();
        chk_res("hs_w1", 1'b1, 64'd25, 64'd25, 64'd1, 1'b0, 1'b0);
        cyc(1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        idle();
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        chk_res("hs_w2_ack_coincident", 1'b1, 64'd2, 64'd2, 64'd1, 1'b0, 1'b0);
        cyc(1'b1, 16'd2, 16'd0, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        idle();
        idle();
        chk_res("hs_w3_overrun", 1'b1, 64'd4, 64'd4, 64'd1, 1'b0, 1'b1);
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        chk_res("hs_ack_clear", 1'b0, 64'd4, 64'd4, 64'd1, 1'b0, 1'b0);

        // Back-to-back loads: a filled window followed by two empty ones.
        cyc(1'b1, 16'd3, 16'd4, 1'b0, 1'b0);
        cyc(1'b1, 16'd3, 16'd4, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        chk_res("b2b_0", 1'b1, 64'd50, 64'd25, 64'd2, 1'b0, 1'b0);
        idle();
        chk_res("b2b_1", 1'b1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        idle();
        chk_res("b2b_2", 1'b1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        chk_res("b2b_ack", 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Saturation: 5 corner samples exceed a 33-bit accumulator.
        for (int k = 0; k < 5; k++) cyc(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        idle();
        idle();
        chk_res("corner_wide", 1'b1, 64'd10737418240, 64'd2147483648, 64'd5, 1'b0, 1'b0);
        chk("sat_valid", {63'd0, b_valid}, 64'd1);
        chk("sat_sum",   {31'd0, b_sum},   64'd8589934591);
        chk("sat_flag",  {63'd0, b_sat},   64'd1);
        chk("sat_peak",  {32'd0, b_peak},  64'd2147483648);
        chk("sat_cnt",   {43'd0, b_cnt},   64'd5);
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'd1, 16'd0, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
        idle();
        idle();
        chk("post_sat_sum",  {31'd0, b_sum}, 64'd1);
        chk("post_sat_flag", {63'd0, b_sat}, 64'd0);
        chk_res("post_sat_wide", 1'b1, 64'd1, 64'd1, 64'd1, 1'b0, 1'b0);
        cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
